sweep_acq_frame_buffer: RTL and testbench

//  Upstream stage of the S-curve sweep acquisition controller. Collects ParallelData words from the

---
 rtl/sdhcal_daq_pkg.sv | 23 ++
 rtl/sweep_acq_sync_fifo.sv | 78 +++++++
 rtl/sweep_acq_frame_buffer.sv | 175 +++++++++++++++++
 tb/tb_sweep_acq_frame_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdhcal_daq_pkg.sv
// ---------------------------------------------------------------------------
// sdhcal_daq_pkg
// Definitions shared between the sweep acquisition frame buffer and the
// sweep controller.
//   - FRAME_WORDS_DEFAULT : words per fire frame. The controller's
//                           DATA_READ_NUM must match this value.
//   - ST_IDLE/FILL/DROP   : frame FSM encodings.
//   - sat_inc16           : saturating 16-bit increment used by event counters.
// ---------------------------------------------------------------------------
package sdhcal_daq_pkg;

    localparam int FRAME_WORDS_DEFAULT = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Returns v + 1. The result sticks at 16'hFFFF instead of wrapping to 0.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/sweep_acq_sync_fifo.sv
// ---------------------------------------------------------------------------
// sweep_acq_sync_fifo
// Synchronous 1R1W FIFO for 16-bit words. It has a registered read port.
// Visibility is set by an external commit pointer. Readers see only the
// words below commit_ptr_i, so a frame that is partly written stays hidden.
// Ports:
//   Clk, reset_n     clock, asynchronous active-low reset
//   clear_i          synchronous flush of both pointers (read data holds)
//   wr_en_i/wr_data_i write one word at wr_ptr
//   commit_ptr_i     end of the committed region (owned by the caller)
//   rden_i           read request. It is ignored while no committed word exists.
//   rd_data_o        registered read data
//   wr_ptr_o         current write pointer
//   used_o           words occupied, committed or not (wr_ptr - rd_ptr)
//   count_o/empty_o  committed words available to the reader
// ---------------------------------------------------------------------------
module sweep_acq_sync_fifo #(
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [15:0]       wr_data_i,
    input  logic [ADDR_W:0]   commit_ptr_i,
    input  logic              rden_i,
    output logic [15:0]       rd_data_o,
    output logic [ADDR_W:0]   wr_ptr_o,
    output logic [ADDR_W:0]   used_o,
    output logic [ADDR_W:0]   count_o,
    output logic              empty_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [15:0]     mem_q [0:DEPTH-1];
    logic [ADDR_W:0] wr_ptr_q;
    logic [ADDR_W:0] rd_ptr_q;
    logic [15:0]     rd_data_q;
    logic            rd_fire_s;

    // The pointers carry one extra wrap bit, so plain subtraction gives the occupancy.
    assign count_o   = commit_ptr_i - rd_ptr_q;
    assign empty_o   = (commit_ptr_i == rd_ptr_q);
    assign used_o    = wr_ptr_q - rd_ptr_q;
    assign rd_fire_s = rden_i & ~empty_o;
    assign wr_ptr_o  = wr_ptr_q;
    assign rd_data_o = rd_data_q;

    // Storage array write port. A flush blocks the write.
    always_ff @(posedge Clk) begin
        if (wr_en_i && !clear_i) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    // Pointers and registered read data. A flush keeps the last read word.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= 16'h0000;
        end else if (clear_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd_fire_s) begin
                rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/sweep_acq_frame_buffer.sv
// ---------------------------------------------------------------------------
// sweep_acq_frame_buffer
// Groups Microroc ParallelData words into frames of FRAME_WORDS words and
// buffers them in a FIFO. A frame is committed or dropped as a whole: the
// free space is checked once, at the first word of the frame. The reader
// sees a frame only after it is committed.
// Configuration macro: DROP_COUNTER_EN adds the DropCount output. DropCount
// counts dropped frames and saturates at 16'hFFFF.
// Ports:
//   Clk, reset_n      clock, asynchronous active-low reset
//   Clear             synchronous flush. It aborts the current frame and clears FrameDropped.
//   ParallelData(_en) readout word and its valid strobe
//   FifoData          registered read data. It is valid the cycle after FifoData_rden.
//   FifoData_rden     read request, one word per cycle
//   FrameReady        1-cycle pulse after a frame commits
//   FifoEmpty         no committed words
//   FifoWordCount     number of committed words
//   FrameDropped      sticky. Set when a frame is discarded for lack of space.
//   DropCount         (DROP_COUNTER_EN only) saturating dropped-frame count
// ---------------------------------------------------------------------------
module sweep_acq_frame_buffer
    import sdhcal_daq_pkg::*;
#(
    parameter int FRAME_WORDS = FRAME_WORDS_DEFAULT,
    parameter int ADDR_W      = 6
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              Clear,
    input  logic [15:0]       ParallelData,
    input  logic              ParallelData_en,
    output logic [15:0]       FifoData,
    input  logic              FifoData_rden,
    output logic              FrameReady,
    output logic              FifoEmpty,
    output logic [ADDR_W:0]   FifoWordCount,
    output logic              FrameDropped
`ifdef DROP_COUNTER_EN
    ,
    output logic [15:0]       DropCount
`endif
);

    localparam logic [3:0]      LAST_IDX    = 4'(FRAME_WORDS - 1);
    localparam logic [ADDR_W:0] SPACE_LIMIT = (ADDR_W + 1)'((1 << ADDR_W) - FRAME_WORDS);
    localparam logic [ADDR_W:0] PTR_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [3:0]      word_idx_q, word_idx_d;
    logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
    logic            frame_ready_q;
    logic            frame_dropped_q;
    logic            wr_en_s, commit_s, drop_done_s, space_ok_s;
    logic [ADDR_W:0] wr_ptr_s, used_s;

    sweep_acq_sync_fifo #(.ADDR_W(ADDR_W)) u_fifo (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .clear_i      (Clear),
        .wr_en_i      (wr_en_s),
        .wr_data_i    (ParallelData),
        .commit_ptr_i (commit_ptr_q),
        .rden_i       (FifoData_rden),
        .rd_data_o    (FifoData),
        .wr_ptr_o     (wr_ptr_s),
        .used_o       (used_s),
        .count_o      (FifoWordCount),
        .empty_o      (FifoEmpty)
    );

    // The check uses used_s, which includes uncommitted words. In IDLE, used_s equals the committed occupancy.
    assign space_ok_s   = (used_s <= SPACE_LIMIT);
    // Committing at the last write makes commit_ptr equal the write pointer after this edge.
    assign commit_ptr_d = commit_s ? (wr_ptr_s + PTR_ONE) : commit_ptr_q;
    assign FrameReady   = frame_ready_q;
    assign FrameDropped = frame_dropped_q;

    // Frame FSM: it accepts or rejects a frame at word 0 and commits or drops it at word FRAME_WORDS-1.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        wr_en_s     = 1'b0;
        commit_s    = 1'b0;
        drop_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ParallelData_en) begin
                    word_idx_d = 4'd1;
                    if (space_ok_s) begin
                        state_d = ST_FILL;
                        wr_en_s = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (ParallelData_en) begin
                    wr_en_s = 1'b1;
                    if (word_idx_q == LAST_IDX) begin
                        commit_s   = 1'b1;
                        state_d    = ST_IDLE;
                        word_idx_d = 4'd0;
                    end else begin
                        word_idx_d = word_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DROP: begin
                if (ParallelData_en) begin
                    if (word_idx_q == LAST_IDX) begin
                        drop_done_s = 1'b1;
                        state_d     = ST_IDLE;
                        word_idx_d  = 4'd0;
                    end else begin
                        word_idx_d = word_idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                word_idx_d = 4'd0;
            end
        endcase
    end

    // FSM state, commit pointer and status flags. Clear overrides every update.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            word_idx_q      <= 4'd0;
            commit_ptr_q    <= '0;
            frame_ready_q   <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else if (Clear) begin
            state_q         <= ST_IDLE;
            word_idx_q      <= 4'd0;
            commit_ptr_q    <= '0;
            frame_ready_q   <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            word_idx_q      <= word_idx_d;
            commit_ptr_q    <= commit_ptr_d;
            frame_ready_q   <= commit_s;
            frame_dropped_q <= frame_dropped_q | drop_done_s;
        end
    end

`ifdef DROP_COUNTER_EN
    logic [15:0] drop_count_q;

    assign DropCount = drop_count_q;

    // Saturating dropped-frame counter.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= 16'h0000;
        end else if (Clear) begin
            drop_count_q <= 16'h0000;
        end else if (drop_done_s) begin
            drop_count_q <= sat_inc16(drop_count_q);
        end else begin
            drop_count_q <= drop_count_q;
        end
    end
`endif

endmodule

// File: tb/tb_sweep_acq_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_sweep_acq_frame_buffer
// Testbench for sweep_acq_frame_buffer. The reference model keeps the
// committed words in a queue and the current frame in a pending list.
// Build with DROP_COUNTER_EN to check DropCount as well.
// ---------------------------------------------------------------------------
module tb_sweep_acq_frame_buffer;
    localparam int FW    = 10;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic        Clk = 1'b0;
    logic        reset_n, Clear, en, rden;
    logic [15:0] pdata, FifoData;
    logic        FrameReady, FifoEmpty, FrameDropped;
    logic [AW:0] FifoWordCount;
`ifdef DROP_COUNTER_EN
    logic [15:0] DropCount;
`endif

    always #5 Clk = ~Clk;

    sweep_acq_frame_buffer #(.FRAME_WORDS(FW), .ADDR_W(AW)) dut (
        .Clk             (Clk),
        .reset_n         (reset_n),
        .Clear           (Clear),
        .ParallelData    (pdata),
        .ParallelData_en (en),
        .FifoData        (FifoData),
        .FifoData_rden   (rden),
        .FrameReady      (FrameReady),
        .FifoEmpty       (FifoEmpty),
        .FifoWordCount   (FifoWordCount),
        .FrameDropped    (FrameDropped)
`ifdef DROP_COUNTER_EN
        ,
        .DropCount       (DropCount)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] cq[$];
    logic [15:0] pend[$];
    bit          in_frame, accept;
    int          cnt;
    bit          m_ready, m_dropped;
    int          m_dcount;
    logic [15:0] m_data;

    typedef struct {
        bit          en;
        logic [15:0] data;
        bit          rden;
        bit          ready;
        int          count;
        bit          empty;
        logic [15:0] dout;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cq.delete();
        pend.delete();
        in_frame  = 1'b0;
        accept    = 1'b0;
        cnt       = 0;
        m_ready   = 1'b0;
        m_dropped = 1'b0;
        m_dcount  = 0;
        m_data    = 16'h0000;
    endtask

    task automatic model_edge(input bit e, input logic [15:0] d, input bit r, input bit c);
        int free_b;
        bit do_rd;
        bit commit;
        if (c) begin
            cq.delete();
            pend.delete();
            in_frame  = 1'b0;
            cnt       = 0;
            m_ready   = 1'b0;
            m_dropped = 1'b0;
            m_dcount  = 0;
            return;
        end
        free_b = DEPTH - cq.size();
        do_rd  = r && (cq.size() != 0);
        commit = 1'b0;
        if (e) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                accept   = (free_b >= FW);
                cnt      = 0;
                pend.delete();
            end
            cnt++;
            if (accept) pend.push_back(d);
            if (cnt == FW) begin
                in_frame = 1'b0;
                if (accept) commit = 1'b1;
                else begin
                    m_dropped = 1'b1;
                    if (m_dcount < 65535) m_dcount++;
                end
            end
        end
        if (do_rd) m_data = cq.pop_front();
        if (commit) begin
            foreach (pend[i]) cq.push_back(pend[i]);
            pend.delete();
        end
        m_ready = commit;
    endtask

    task automatic check_all();
        chk("ready",    32'(FrameReady),    32'(m_ready));
        chk("empty",    32'(FifoEmpty),     32'(cq.size() == 0));
        chk("count",    32'(FifoWordCount), 32'(cq.size()));
        chk("dropped",  32'(FrameDropped),  32'(m_dropped));
        chk("fifodata", 32'(FifoData),      32'(m_data));
`ifdef DROP_COUNTER_EN
        chk("dropcount", 32'(DropCount),    32'(m_dcount));
`endif
    endtask

    task automatic cycle(input bit e, input logic [15:0] d, input bit r, input bit c);
        en = e; pdata = d; rden = r; Clear = c;
        @(posedge Clk);
        model_edge(e, d, r, c);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH && cq.size() != 0; k++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; Clear = 1'b0; en = 1'b0; rden = 1'b0; pdata = 16'h0000;
        model_reset();

        // Test 1 vectors: 10 words back-to-back, one idle cycle, 10 reads, one read while empty
        for (int i = 0; i < 22; i++) begin
            tbl[i].en   = (i < 10);
            tbl[i].data = (i < 10) ? 16'(i + 1) : 16'h0000;
            tbl[i].rden = (i >= 11);
            tbl[i].ready = (i == 9);
            tbl[i].count = (i < 9) ? 0 : (i <= 10) ? 10 : (i <= 20) ? (20 - i) : 0;
            tbl[i].empty = (tbl[i].count == 0);
            tbl[i].dout  = (i <= 10) ? 16'h0000 : (i <= 20) ? 16'(i - 10) : 16'h000A;
        end

        repeat (2) @(posedge Clk);
        #1;
        check_all();
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].en, tbl[i].data, tbl[i].rden, 1'b0);
            chk("t1_ready", 32'(FrameReady),    32'(tbl[i].ready));
            chk("t1_count", 32'(FifoWordCount), 32'(tbl[i].count));
            chk("t1_empty", 32'(FifoEmpty),     32'(tbl[i].empty));
            chk("t1_data",  32'(FifoData),      32'(tbl[i].dout));
        end

        // Test 2: gaps of 1-3 idle cycles between the words
        for (int w = 1; w <= FW; w++) begin
            cycle(1'b1, 16'(16'h0100 + w), 1'b0, 1'b0);
            if (w < FW) chk("t2_no_early_ready", 32'(FrameReady), 32'd0);
            repeat ($urandom_range(1, 3)) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        chk("t2_count", 32'(FifoWordCount), 32'd10);
        drain();

        // Test 3: 7 frames with no reads. The 7th frame is dropped.
        for (int f = 0; f < 7; f++)
            for (int w = 0; w < FW; w++) cycle(1'b1, 16'(16'h2000 + f * 16 + w), 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("t3_count",   32'(FifoWordCount), 32'd60);
        chk("t3_dropped", 32'(FrameDropped),  32'd1);
`ifdef DROP_COUNTER_EN
        chk("t3_dropcount", 32'(DropCount), 32'd1);
`endif
        drain();

        // Test 4: a read in the same cycle as a commit gives count old+FW-1
        for (int w = 0; w < FW; w++) cycle(1'b1, 16'(16'h3000 + w), 1'b0, 1'b0);
        for (int w = 0; w < FW - 1; w++) cycle(1'b1, 16'(16'h3100 + w), 1'b0, 1'b0);
        cycle(1'b1, 16'h3109, 1'b1, 1'b0);
        chk("t4_commit_read", 32'(FifoWordCount), 32'd19);
        drain();
        // Random traffic. It wraps the pointers several times and causes some drops.
        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 5,
                  $urandom_range(0, 199) == 0);
        drain();

        // Test 5: Clear after 5 words of a frame
        for (int w = 0; w < FW; w++) cycle(1'b1, 16'(16'h5000 + w), 1'b0, 1'b0);
        for (int w = 0; w < 5; w++) cycle(1'b1, 16'(16'h5100 + w), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
        chk("t5_empty", 32'(FifoEmpty),     32'd1);
        chk("t5_count", 32'(FifoWordCount), 32'd0);
        for (int w = 0; w < FW; w++) cycle(1'b1, 16'(16'h5200 + w), 1'b0, 1'b0);
        chk("t5_recommit", 32'(FifoWordCount), 32'd10);
        drain();

        // Test 6: rden while empty, then reset in the middle of a frame
        repeat (3) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("t6_hold", 32'(FifoData), 32'h5209);
        for (int w = 0; w < 4; w++) cycle(1'b1, 16'(16'h6000 + w), 1'b0, 1'b0);
        en = 1'b0; rden = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("t6_rst_data", 32'(FifoData), 32'd0);
        @(posedge Clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("t6_no_ready", 32'(FrameReady), 32'd0);
        for (int w = 0; w < FW; w++) cycle(1'b1, 16'(16'h6100 + w), 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
